fixed_point_addsub_pipe: RTL and testbench

//  Multi-lane pipelined fixed-point adder/subtractor, Q(WIDTH-FBITS-1).FBITS two's complement.
//  Per-transaction add/sub and saturate/wrap selection; per-lane and sticky overflow flags.

---
 rtl/fxp_pkg.sv | 16 +
 rtl/fxp_addsub_lane.sv | 41 ++++
 rtl/fixed_point_addsub_pipe.sv | 126 ++++++++++++
 tb/tb_fixed_point_addsub_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared types and range helpers for the fixed-point add/sub pipeline
package fxp_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  typedef enum logic {SAT = 1'b0, WRAP = 1'b1} ovf_mode_e;

  // Results are 64 bits wide; callers keep the low W bits.
  function automatic logic [63:0] fxp_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fxp_min(input int w);
    return ~fxp_max(w);
  endfunction

endpackage

// File: rtl/fxp_addsub_lane.sv
// rtl/fxp_addsub_lane.sv - one lane: extended sum/difference and saturate/wrap resolution
module fxp_addsub_lane
  import fxp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_op,
  output logic [WIDTH:0]   o_ext,
  input  logic [WIDTH:0]   i_ext,
  input  ovf_mode_e        i_mode,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovf
);

  localparam logic [63:0] MAX64 = fxp_max(WIDTH);
  localparam logic [63:0] MIN64 = fxp_min(WIDTH);

  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_b_op;
  logic           w_is_sub;

  assign w_is_sub = (i_op == OP_SUB);
  assign w_a      = {i_a[WIDTH-1], i_a};
  assign w_b      = {i_b[WIDTH-1], i_b};
  // One extra bit makes negating the most negative operand exact.
  assign w_b_op   = w_is_sub ? ~w_b : w_b;
  assign o_ext    = w_a + w_b_op + {{WIDTH{1'b0}}, w_is_sub};

  assign o_ovf = i_ext[WIDTH] ^ i_ext[WIDTH-1];

  always_comb begin
    o_res = i_ext[WIDTH-1:0];
    if (o_ovf && (i_mode == SAT)) begin
      o_res = i_ext[WIDTH] ? MIN64[WIDTH-1:0] : MAX64[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// rtl/fixed_point_addsub_pipe.sv - 2-stage multi-lane fixed-point add/sub with valid/ready and sticky overflow
// Optional per-lane overflow counters: define FXP_ADDSUB_OVF_CNT_EN.
module fixed_point_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FBITS = 4,
  parameter int LANES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_sub,
  input  logic                   i_wrap,
  input  logic [LANES*WIDTH-1:0] i_a,
  input  logic [LANES*WIDTH-1:0] i_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_val,
  output logic [LANES-1:0]       o_ovf,
  output logic [LANES-1:0]       o_ovf_sticky,
  input  logic                   i_clr_sticky
`ifdef FXP_ADDSUB_OVF_CNT_EN
  ,
  output logic [LANES*16-1:0]    o_ovf_cnt
`endif
);

  logic                          w_adv1;
  logic                          w_adv2;
  logic                          w_deliver;
  logic [LANES-1:0]              w_set;
  logic [LANES-1:0][WIDTH:0]     w_ext;
  logic [LANES-1:0][WIDTH-1:0]   w_res;
  logic [LANES-1:0]              w_ovf;

  logic                          r_s1_valid;
  logic [LANES-1:0][WIDTH:0]     r_s1_ext;
  ovf_mode_e                     r_s1_mode;
  logic                          r_o_valid;
  logic [LANES-1:0][WIDTH-1:0]   r_o_val;
  logic [LANES-1:0]              r_o_ovf;
  logic [LANES-1:0]              r_sticky;

  assign w_adv2    = !r_o_valid || i_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign o_ready   = w_adv1;
  assign w_deliver = r_o_valid && i_ready;
  assign w_set     = w_deliver ? r_o_ovf : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fxp_addsub_lane #(.WIDTH(WIDTH)) u_lane (
      .i_a    (i_a[k*WIDTH +: WIDTH]),
      .i_b    (i_b[k*WIDTH +: WIDTH]),
      .i_op   (op_e'(i_sub)),
      .o_ext  (w_ext[k]),
      .i_ext  (r_s1_ext[k]),
      .i_mode (r_s1_mode),
      .o_res  (w_res[k]),
      .o_ovf  (w_ovf[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ext   <= '0;
      r_s1_mode  <= SAT;
      r_o_valid  <= 1'b0;
      r_o_val    <= '0;
      r_o_ovf    <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= i_valid;
        if (i_valid) begin
          r_s1_ext  <= w_ext;
          r_s1_mode <= ovf_mode_e'(i_wrap);
        end
      end
      // Stage 2 only moves when the held beat is taken, keeping o_val stable under stall.
      if (w_adv2) begin
        r_o_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_o_val <= w_res;
          r_o_ovf <= w_ovf;
        end
      end
    end
  end

  // A clear coinciding with a new overflow keeps the new event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (i_clr_sticky ? '0 : r_sticky) | w_set;
    end
  end

  assign o_valid      = r_o_valid;
  assign o_val        = r_o_val;
  assign o_ovf        = r_o_ovf;
  assign o_ovf_sticky = r_sticky;

`ifdef FXP_ADDSUB_OVF_CNT_EN
  logic [LANES-1:0][15:0] r_ovf_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_cnt <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (i_clr_sticky) begin
          r_ovf_cnt[k] <= {15'd0, w_set[k]};
        end else if (w_set[k] && (r_ovf_cnt[k] != 16'hFFFF)) begin
          r_ovf_cnt[k] <= r_ovf_cnt[k] + 16'd1;
        end
      end
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// tb/tb_fixed_point_addsub_pipe.sv - scoreboard bench for fixed_point_addsub_pipe (WIDTH=8, LANES=2)
module tb_fixed_point_addsub_pipe;

  typedef struct packed {
    logic [15:0] val;
    logic [1:0]  ovf;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sub = 1'b0;
  logic        i_wrap = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_val;
  logic [1:0]  o_ovf;
  logic [1:0]  o_ovf_sticky;
  logic        i_clr_sticky = 1'b0;
`ifdef FXP_ADDSUB_OVF_CNT_EN
  logic [31:0] o_ovf_cnt;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  always #5 i_clk = ~i_clk;

  fixed_point_addsub_pipe #(.WIDTH(8), .FBITS(4), .LANES(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_sub        (i_sub),
    .i_wrap       (i_wrap),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_val        (o_val),
    .o_ovf        (o_ovf),
    .o_ovf_sticky (o_ovf_sticky),
    .i_clr_sticky (i_clr_sticky)
`ifdef FXP_ADDSUB_OVF_CNT_EN
    ,
    .o_ovf_cnt    (o_ovf_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at negedge+1; outputs are sampled by the monitor at negedge+2.
  task automatic send(input logic sub, input logic wrap, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] ev, input logic [1:0] eo,
                      input bit push);
    bit ok;
    ok = 1'b0;
    @(negedge i_clk);
    #1;
    i_valid = 1'b1; i_sub = sub; i_wrap = wrap; i_a = a; i_b = b;
    for (int t = 0; t < 50; t++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (ok && push) q.push_back('{val: ev, ovf: eo});
    @(posedge i_clk);
  endtask

  task automatic idle();
    @(negedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge i_clk);
      #3;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", q.size(), 32'd0);
    @(negedge i_clk);
    #3;
  endtask

  task automatic clr_pulse();
    @(negedge i_clk);
    i_clr_sticky = 1'b1;
    @(negedge i_clk);
    i_clr_sticky = 1'b0;
    #3;
  endtask

  logic        prev_stall = 1'b0;
  logic [15:0] held_val = '0;
  logic [1:0]  held_ovf = '0;

  always begin
    exp_t e;
    @(negedge i_clk);
    #2;
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (o_valid && prev_stall) begin
        chk("stall_val_stable", o_val, held_val);
        chk("stall_ovf_stable", o_ovf, held_ovf);
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", o_val, 32'hDEAD);
        end else begin
          e = q.pop_front();
          chk("o_val", o_val, e.val);
          chk("o_ovf", o_ovf, e.ovf);
        end
      end
      prev_stall = o_valid && !i_ready;
      held_val   = o_val;
      held_ovf   = o_ovf;
    end
  end

  initial begin
    bit seen;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    #3;
    chk("rst_o_valid", o_valid, 32'd0);
    chk("rst_o_val", o_val, 32'd0);
    chk("rst_o_ready", o_ready, 32'd1);
    chk("rst_sticky", o_ovf_sticky, 32'd0);

    // Saturating add then subtract, back to back.
    send(1'b0, 1'b0, 16'h7F30, 16'h0120, 16'h7F50, 2'b10, 1'b1);
    send(1'b1, 1'b0, 16'h0080, 16'h8001, 16'h7F80, 2'b11, 1'b1);
    idle();
    drain();
    chk("sticky_after_sat", o_ovf_sticky, 32'd3);

    clr_pulse();
    chk("sticky_clear_1", o_ovf_sticky, 32'd0);

    send(1'b0, 1'b1, 16'h107F, 16'h0501, 16'h1580, 2'b01, 1'b1);
    idle();
    drain();
    chk("sticky_after_wrap", o_ovf_sticky, 32'd1);

    send(1'b0, 1'b1, 16'h8080, 16'hFF80, 16'h7F00, 2'b11, 1'b1);
    idle();
    drain();
    chk("sticky_after_negwrap", o_ovf_sticky, 32'd3);

    // Four beats streamed with a 3-cycle downstream stall.
    fork
      begin
        send(1'b0, 1'b0, 16'h0201, 16'h0403, 16'h0604, 2'b00, 1'b1);
        send(1'b1, 1'b1, 16'h2010, 16'h0201, 16'h1E0F, 2'b00, 1'b1);
        send(1'b0, 1'b0, 16'hC0F0, 16'hC0F0, 16'h80E0, 2'b00, 1'b1);
        send(1'b1, 1'b0, 16'h00FF, 16'h7F01, 16'h81FE, 2'b00, 1'b1);
        idle();
      end
      begin
        repeat (3) @(negedge i_clk);
        i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        i_ready = 1'b1;
      end
    join
    drain();

    clr_pulse();
    chk("sticky_clear_2", o_ovf_sticky, 32'd0);

    // Clear arriving in the same cycle as an overflowing delivery.
    @(negedge i_clk);
    i_ready = 1'b0;
    send(1'b1, 1'b0, 16'h0080, 16'h8001, 16'h7F80, 2'b11, 1'b1);
    idle();
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge i_clk);
      #2;
      if (o_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("hold_timeout", 32'd0, 32'd1);
    @(negedge i_clk);
    i_ready = 1'b1;
    i_clr_sticky = 1'b1;
    @(negedge i_clk);
    i_clr_sticky = 1'b0;
    #3;
    chk("sticky_set_wins", o_ovf_sticky, 32'd3);
    drain();
    clr_pulse();
    chk("sticky_clear_3", o_ovf_sticky, 32'd0);

    // Reset while a beat is in flight: it must never appear.
    @(negedge i_clk);
    i_ready = 1'b0;
    send(1'b0, 1'b0, 16'h7F30, 16'h0120, 16'h7F50, 2'b10, 1'b0);
    idle();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_ready = 1'b1;
    repeat (4) @(negedge i_clk);
    #3;
    chk("midrst_o_valid", o_valid, 32'd0);
    chk("midrst_sticky", o_ovf_sticky, 32'd0);
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
